// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, error report, read-request beat and
// read-streamer state encoding, plus the AXI size helper.
`timescale 1ns/1ps
package dma_pkg;

    localparam int DMA_ADDR_W      = 32;
    localparam int DMA_LEN_W       = 32;
    localparam int DMA_4K_BOUNDARY = 4096;

    typedef enum logic [1:0] {
        DMA_ERR_SRC_NONE = 2'd0,
        DMA_ERR_SRC_RD   = 2'd1,
        DMA_ERR_SRC_WR   = 2'd2
    } dma_err_src_t;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] src_addr;
        logic [DMA_ADDR_W-1:0] dst_addr;
        logic [DMA_LEN_W-1:0]  num_bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic                  valid;
        dma_err_src_t          src;
        logic [DMA_ADDR_W-1:0] addr;
    } s_dma_error_t;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
    } s_dma_rd_req_t;

    typedef enum logic [2:0] {
        RD_IDLE = 3'd0,
        RD_CALC = 3'd1,
        RD_REQ  = 3'd2,
        RD_FIN  = 3'd3,
        RD_WAIT = 3'd4
    } rd_state_t;

    // AXI AxSIZE encoding for a given number of bytes per beat.
    function automatic logic [2:0] axi_size(input int bpb);
        return 3'($clog2(bpb));
    endfunction

endpackage

// File: rtl/dma_rd_streamer_if.sv
// Burst read-request channel between the read streamer and the AXI
// read-address front end.
`timescale 1ns/1ps
interface dma_rd_streamer_if #(
    parameter int ADDR_W = 32
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [7:0]        rd_req_len;
    logic [2:0]        rd_req_size;

    modport master (
        output rd_req_valid,
        output rd_req_addr,
        output rd_req_len,
        output rd_req_size,
        input  rd_req_ready
    );

    modport slave (
        input  rd_req_valid,
        input  rd_req_addr,
        input  rd_req_len,
        input  rd_req_size,
        output rd_req_ready
    );
endinterface

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: the next burst is the smallest of the beats
// still owed, the burst cap, and the beats left before the next 4 KiB page.
// Address is assumed beat-aligned. Shared with the write streamer.
`timescale 1ns/1ps
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int BPB       = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 32
) (
    input  logic [11:0]      addr_lo_i,
    input  logic [CNT_W-1:0] beats_rem_i,
    output logic [7:0]       len_o
);
    localparam int              OFF_W      = $clog2(BPB);
    localparam logic [12:0]     PAGE_BYTES = 13'(DMA_4K_BOUNDARY);
    localparam logic [CNT_W-1:0] CAP_BEATS = CNT_W'(MAX_BEATS);

    logic [12:0]      room_bytes_s;
    logic [12:0]      room_beats_s;
    logic [CNT_W-1:0] capped_s;
    logic [CNT_W-1:0] beats_s;

    // Minimum of remaining beats, burst cap and room in the current page.
    always_comb begin
        room_bytes_s = PAGE_BYTES - {1'b0, addr_lo_i};
        room_beats_s = room_bytes_s >> OFF_W;
        if (beats_rem_i < CAP_BEATS) begin
            capped_s = beats_rem_i;
        end else begin
            capped_s = CAP_BEATS;
        end
        if (CNT_W'(room_beats_s) < capped_s) begin
            beats_s = CNT_W'(room_beats_s);
        end else begin
            beats_s = capped_s;
        end
        len_o = 8'(beats_s - CNT_W'(1));
    end
endmodule

// File: rtl/dma_rd_streamer.sv
// Read-side streamer: splits the active descriptor's source region into
// AXI INCR read bursts and reports done/error back to the DMA control FSM.
`timescale 1ns/1ps
module dma_rd_streamer
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dma_stream_rd_valid_i,
    input  s_dma_desc_t       dma_desc_i,
    output logic              dma_stream_rd_done_o,
    output s_dma_error_t      dma_stream_rd_err_o,
    dma_rd_streamer_if.master rd_req
);
    localparam int BPB   = DATA_W / 8;
    localparam int OFF_W = $clog2(BPB);
    localparam int CNT_W = DMA_LEN_W;
    localparam logic [2:0]            RD_SIZE    = axi_size(BPB);
    localparam logic [DMA_ADDR_W-1:0] ADDR_ALIGN = DMA_ADDR_W'(BPB - 1);
    localparam logic [CNT_W-1:0]      LEN_ALIGN  = CNT_W'(BPB - 1);

    rd_state_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  beats_q;
    logic [7:0]        len_q;
    logic              req_valid_q;
    logic              done_q;
    s_dma_error_t      err_q;

    logic [7:0]        calc_len_s;
    logic [CNT_W-1:0]  burst_beats_s;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  beats_d;
    logic              desc_zero_s;
    logic              desc_misaligned_s;
    s_dma_rd_req_t     req_s;
    logic              unused_desc_s;

    // Destination address belongs to the write side.
    assign unused_desc_s = ^dma_desc_i.dst_addr;

    dma_burst_calc #(
        .BPB       (BPB),
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) u_burst_calc (
        .addr_lo_i   (addr_q[11:0]),
        .beats_rem_i (beats_q),
        .len_o       (calc_len_s)
    );

    // Descriptor qualification and post-handshake address/beat bookkeeping.
    always_comb begin
        desc_zero_s       = (dma_desc_i.num_bytes == '0);
        desc_misaligned_s = ((dma_desc_i.src_addr & ADDR_ALIGN) != '0) ||
                            ((dma_desc_i.num_bytes & LEN_ALIGN) != '0);
        burst_beats_s     = CNT_W'(len_q) + CNT_W'(1);
        addr_d            = addr_q + (ADDR_W'(burst_beats_s) << OFF_W);
        beats_d           = beats_q - burst_beats_s;
    end

    // Burst-splitting FSM with registered request, done and error outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            beats_q     <= '0;
            len_q       <= 8'd0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    done_q      <= 1'b0;
                    err_q       <= '0;
                    req_valid_q <= 1'b0;
                    if (dma_stream_rd_valid_i) begin
                        addr_q  <= ADDR_W'(dma_desc_i.src_addr);
                        beats_q <= dma_desc_i.num_bytes >> OFF_W;
                        if (desc_zero_s) begin
                            state_q <= RD_FIN;
                            done_q  <= 1'b1;
                        end else if (desc_misaligned_s) begin
                            state_q     <= RD_FIN;
                            done_q      <= 1'b1;
                            err_q.valid <= 1'b1;
                            err_q.src   <= DMA_ERR_SRC_RD;
                            err_q.addr  <= dma_desc_i.src_addr;
                        end else begin
                            state_q <= RD_CALC;
                        end
                    end
                end
                RD_CALC: begin
                    if (dma_stream_rd_valid_i) begin
                        len_q       <= calc_len_s;
                        req_valid_q <= 1'b1;
                        state_q     <= RD_REQ;
                    end else begin
                        // Request withdrawn between bursts: wrap up cleanly.
                        done_q  <= 1'b1;
                        state_q <= RD_FIN;
                    end
                end
                RD_REQ: begin
                    if (rd_req.rd_req_ready) begin
                        req_valid_q <= 1'b0;
                        addr_q      <= addr_d;
                        beats_q     <= beats_d;
                        if ((beats_d == '0) || !dma_stream_rd_valid_i) begin
                            done_q  <= 1'b1;
                            state_q <= RD_FIN;
                        end else begin
                            state_q <= RD_CALC;
                        end
                    end
                end
                RD_FIN: begin
                    done_q  <= 1'b0;
                    err_q   <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Hold off until the control FSM withdraws its request.
                    if (!dma_stream_rd_valid_i) begin
                        state_q <= RD_IDLE;
                    end
                end
                default: begin
                    state_q     <= RD_IDLE;
                    req_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                    err_q       <= '0;
                end
            endcase
        end
    end

    assign req_s.addr  = DMA_ADDR_W'(addr_q);
    assign req_s.len   = len_q;
    assign req_s.size  = RD_SIZE;

    assign rd_req.rd_req_valid  = req_valid_q;
    assign rd_req.rd_req_addr   = ADDR_W'(req_s.addr);
    assign rd_req.rd_req_len    = req_s.len;
    assign rd_req.rd_req_size   = req_s.size;
    assign dma_stream_rd_done_o = done_q;
    assign dma_stream_rd_err_o  = err_q;
endmodule

// File: tb/tb_dma_rd_streamer.sv
// Self-checking bench for dma_rd_streamer: directed cases from the burst
// rules plus randomized descriptors, checked against a burst-list model.
`timescale 1ns/1ps
module tb_dma_rd_streamer;
    import dma_pkg::*;

    localparam int BPB = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rd_valid;
    s_dma_desc_t  desc;
    logic         done;
    s_dma_error_t err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_a[$];
    logic [7:0]  exp_l[$];

    dma_rd_streamer_if #(.ADDR_W(32)) bus();

    dma_rd_streamer #(
        .ADDR_W    (32),
        .DATA_W    (64),
        .MAX_BEATS (16)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .dma_stream_rd_valid_i (rd_valid),
        .dma_desc_i            (desc),
        .dma_stream_rd_done_o  (done),
        .dma_stream_rd_err_o   (err),
        .rd_req                (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Burst list from the descriptor: cap 16 beats, never cross 4 KiB.
    function automatic void build_model(input logic [31:0] src, input logic [31:0] nbytes);
        logic [31:0] a;
        int unsigned rem, room, b;
        exp_a.delete();
        exp_l.delete();
        if (nbytes == 0 || (src % BPB) != 0 || (nbytes % BPB) != 0) return;
        a   = src;
        rem = nbytes / BPB;
        while (rem > 0) begin
            room = (4096 - (a % 4096)) / BPB;
            b = rem;
            if (b > 16) b = 16;
            if (b > room) b = room;
            exp_a.push_back(a);
            exp_l.push_back(8'(b - 1));
            a   = a + 32'(b * BPB);
            rem = rem - b;
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, ":done"}, done, 0);
        check({tag, ":err"}, err, 0);
        check({tag, ":req_valid"}, bus.rd_req_valid, 0);
        check({tag, ":req_addr"}, bus.rd_req_addr, 0);
        check({tag, ":req_len"}, bus.rd_req_len, 0);
        check({tag, ":req_size"}, bus.rd_req_size, 3);
    endtask

    // mode 0: ready=1, mode 1: random ready, mode 2: 5 stall cycles per request.
    task automatic run_txn(input string tag, input logic [31:0] src, input logic [31:0] nbytes,
                           input int mode, input bit launched);
        logic [31:0] obs_a[$];
        logic [7:0]  obs_l[$];
        int done_cyc = -1, err_cyc = -1, ndone = 0, nerr = 0;
        int first_req = -1, first_hs = -1, last_hs = -1, unstable = 0, stall = 0, nb, ncmp;
        logic [31:0] err_addr = '0;
        logic [1:0]  err_src = '0;
        bit hold = 1'b0, exp_err, rdy;
        logic [31:0] held_a = '0;
        logic [7:0]  held_l = '0;

        build_model(src, nbytes);
        nb = exp_a.size();
        exp_err = (nbytes != 0) && (((src % BPB) != 0) || ((nbytes % BPB) != 0));
        if (!launched) begin
            @(negedge clk);
            desc.src_addr  = src;
            desc.dst_addr  = $urandom;
            desc.num_bytes = nbytes;
            rd_valid       = 1'b1;
        end
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (hold && !(bus.rd_req_valid === 1'b1 && bus.rd_req_addr === held_a &&
                          bus.rd_req_len === held_l)) unstable++;
            hold = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    rd_valid = 1'b0;
                end
            end
            if (err.valid === 1'b1) begin
                nerr++;
                err_cyc  = cyc;
                err_addr = err.addr;
                err_src  = err.src;
            end
            rdy = 1'b0;
            if (bus.rd_req_valid === 1'b1) begin
                if (first_req < 0) first_req = cyc;
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = (stall >= 5);
                endcase
                if (rdy) begin
                    obs_a.push_back(bus.rd_req_addr);
                    obs_l.push_back(bus.rd_req_len);
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    stall   = 0;
                end else begin
                    hold   = 1'b1;
                    held_a = bus.rd_req_addr;
                    held_l = bus.rd_req_len;
                    stall++;
                end
            end else if (mode == 1) begin
                rdy = 1'($urandom_range(0, 1));
            end
            bus.rd_req_ready = rdy;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        rd_valid = 1'b0;
        bus.rd_req_ready = 1'b0;

        check({tag, ":done_seen"}, done_cyc >= 0, 1);
        check({tag, ":done_count"}, ndone, 1);
        check({tag, ":done_cycle"}, done_cyc, (nb == 0) ? 1 : last_hs + 1);
        check({tag, ":first_req_cycle"}, first_req, (nb == 0) ? -1 : 2);
        if (mode == 0 && nb > 0) check({tag, ":last_hs_cycle"}, last_hs, 2 * nb);
        if (mode == 2 && nb > 0) check({tag, ":stalled_hs_cycle"}, first_hs, 7);
        check({tag, ":burst_count"}, obs_a.size(), nb);
        ncmp = (obs_a.size() < nb) ? obs_a.size() : nb;
        for (int i = 0; i < ncmp; i++) begin
            check({tag, $sformatf(":addr%0d", i)}, obs_a[i], exp_a[i]);
            check({tag, $sformatf(":len%0d", i)}, obs_l[i], exp_l[i]);
        end
        check({tag, ":err_count"}, nerr, exp_err ? 1 : 0);
        if (exp_err) begin
            check({tag, ":err_addr"}, err_addr, src);
            check({tag, ":err_src"}, err_src, DMA_ERR_SRC_RD);
            check({tag, ":err_cycle"}, err_cyc, done_cyc);
        end
        check({tag, ":stable_while_stalled"}, unstable, 0);

        if (done_cyc < 0) begin
            rstn = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
        end
        repeat (2) @(negedge clk);
        check({tag, ":quiet_done"}, done, 0);
        check({tag, ":quiet_req"}, bus.rd_req_valid, 0);
    endtask

    initial begin
        logic [31:0] src, nbytes;
        int seen, kind;

        rstn = 1'b0;
        rd_valid = 1'b0;
        desc = '0;
        bus.rd_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_txn("two_bursts",   32'h0000_1000, 32'd256, 0, 1'b0);
        run_txn("page_split",   32'h0000_0FF0, 32'd64,  0, 1'b0);
        run_txn("zero_len",     32'h0000_2000, 32'd0,   0, 1'b0);
        run_txn("misaligned",   32'h0000_1004, 32'd64,  0, 1'b0);
        run_txn("odd_bytes",    32'h0000_3000, 32'd20,  0, 1'b0);
        run_txn("stall5",       32'h0000_1000, 32'd256, 2, 1'b0);
        run_txn("addr_wrap",    32'hFFFF_FFC0, 32'd128, 0, 1'b0);
        run_txn("single_beat",  32'h0000_0FF8, 32'd8,   1, 1'b0);

        // Reset while the second request is pending, then relaunch.
        @(negedge clk);
        desc.src_addr  = 32'h0000_1000;
        desc.dst_addr  = 32'h0;
        desc.num_bytes = 32'd256;
        rd_valid = 1'b1;
        bus.rd_req_ready = 1'b1;
        seen = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (bus.rd_req_valid === 1'b1) begin
                seen++;
                if (seen == 2) begin
                    rstn = 1'b0;
                    break;
                end
            end
        end
        bus.rd_req_ready = 1'b0;
        check("mid_reset:second_req_seen", seen, 2);
        #1;
        check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        check_idle_outputs("mid_reset_hold");
        rstn = 1'b1;
        run_txn("restart", 32'h0000_1000, 32'd256, 0, 1'b1);

        for (int t = 0; t < 24; t++) begin
            kind   = $urandom_range(0, 5);
            src    = $urandom & 32'hFFFF_FFF8;
            nbytes = 32'($urandom_range(1, 96) * 8);
            case (kind)
                0:       src = {src[31:12], 12'hF00} + 32'($urandom_range(0, 31) * 8);
                1:       nbytes = 32'd0;
                2:       src = src | 32'($urandom_range(1, 7));
                3:       nbytes = nbytes + 32'($urandom_range(1, 7));
                default: src = src;
            endcase
            run_txn($sformatf("rand%0d", t), src, nbytes, $urandom_range(0, 2), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
